// File: rtl/obstacle_animator.sv
// Animates one rectangular obstacle moving right-to-left across the VGA frame.
// It erases and redraws the obstacle through the vga_adapter pixel port and respawns it at a pseudo-random row.
module obstacle_animator #(
    parameter int unsigned OBJ_W     = 4,
    parameter int unsigned OBJ_H     = 4,
    parameter int unsigned SCREEN_W  = 160,
    parameter int unsigned SCREEN_H  = 120,
    parameter int unsigned STEP      = 1,
    parameter int unsigned FRAME_DIV = 833333,
    parameter logic [2:0]  COLOUR    = 3'b111,
    parameter logic [2:0]  BG        = 3'b000,
    parameter logic [9:0]  SEED      = 10'h094
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic [7:0] obj_x,
    output logic [6:0] obj_y,
    output logic       passed,
    output logic       busy
);

    localparam int unsigned XW = 8;
    localparam int unsigned YW = 7;
    localparam int unsigned PW = 4;
    localparam int unsigned LW = 10;
    localparam int unsigned CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [XW-1:0] SPAWN_X  = XW'(SCREEN_W - OBJ_W);
    localparam logic [YW-1:0] YLIM     = YW'(SCREEN_H - OBJ_H);
    localparam logic [PW-1:0] LAST_PX  = PW'(OBJ_W - 1);
    localparam logic [PW-1:0] LAST_PY  = PW'(OBJ_H - 1);
    localparam logic [XW-1:0] STEP_X   = XW'(STEP);
    localparam logic [CW-1:0] DIV_LAST = CW'(FRAME_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_DRAW,
        S_WAIT,
        S_ERASE,
        S_MOVE,
        S_EXIT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_tick_cnt;
    logic            w_tick;
    logic [LW-1:0]   r_lfsr;
    logic [LW-1:0]   w_lfsr_nxt;
    logic [PW-1:0]   r_px;
    logic [PW-1:0]   r_py;
    logic [PW-1:0]   w_px_nxt;
    logic [PW-1:0]   w_py_nxt;
    logic [XW-1:0]   r_obj_x;
    logic [XW-1:0]   w_obj_x_nxt;
    logic [YW-1:0]   r_obj_y;
    logic [YW-1:0]   w_obj_y_nxt;
    logic [YW-1:0]   w_rand;
    logic [YW-1:0]   w_row;
    logic            w_last_pix;

    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [2:0]      r_colour;
    logic            r_plot;
    logic            r_passed;
    logic            r_busy;
    logic [XW-1:0]   w_x_nxt;
    logic [YW-1:0]   w_y_nxt;
    logic [2:0]      w_colour_nxt;
    logic            w_plot_nxt;
    logic            w_passed_nxt;

    // Free-running frame tick; only the WAIT state consumes it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == DIV_LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + CW'(1);
        end
    end

    assign w_tick = (r_tick_cnt == DIV_LAST);

    // Fold out-of-range rows back into the valid band so every spawn fits on screen.
    assign w_rand     = r_lfsr[6:0];
    assign w_row      = (w_rand <= YLIM) ? w_rand : (w_rand - (YLIM + YW'(1)));
    assign w_last_pix = (r_px == LAST_PX) && (r_py == LAST_PY);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_px_nxt    = r_px;
        w_py_nxt    = r_py;
        w_obj_x_nxt = r_obj_x;
        w_obj_y_nxt = r_obj_y;
        w_lfsr_nxt  = r_lfsr;

        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_state_nxt = S_SPAWN;
                end
            end
            S_SPAWN: begin
                w_obj_x_nxt = SPAWN_X;
                w_obj_y_nxt = w_row;
                w_lfsr_nxt  = {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
                w_px_nxt    = '0;
                w_py_nxt    = '0;
                w_state_nxt = S_DRAW;
            end
            S_DRAW, S_ERASE: begin
                if (w_last_pix) begin
                    w_px_nxt = '0;
                    w_py_nxt = '0;
                    if (r_state == S_DRAW) begin
                        w_state_nxt = S_WAIT;
                    end else if (r_obj_x < STEP_X) begin
                        w_state_nxt = S_EXIT;
                    end else begin
                        w_state_nxt = S_MOVE;
                    end
                end else if (r_px == LAST_PX) begin
                    w_px_nxt = '0;
                    w_py_nxt = r_py + PW'(1);
                end else begin
                    w_px_nxt = r_px + PW'(1);
                end
            end
            S_WAIT: begin
                if (w_tick && go) begin
                    w_px_nxt    = '0;
                    w_py_nxt    = '0;
                    w_state_nxt = S_ERASE;
                end
            end
            S_MOVE: begin
                w_obj_x_nxt = r_obj_x - STEP_X;
                w_px_nxt    = '0;
                w_py_nxt    = '0;
                w_state_nxt = S_DRAW;
            end
            S_EXIT: begin
                w_state_nxt = S_SPAWN;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pixel outputs are computed from the next state so they line up with the scan registers.
    always_comb begin
        w_plot_nxt   = (w_state_nxt == S_DRAW) || (w_state_nxt == S_ERASE);
        w_passed_nxt = (w_state_nxt == S_EXIT);
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_colour_nxt = r_colour;
        if (w_plot_nxt) begin
            w_x_nxt      = w_obj_x_nxt + XW'(w_px_nxt);
            w_y_nxt      = w_obj_y_nxt + YW'(w_py_nxt);
            w_colour_nxt = (w_state_nxt == S_DRAW) ? COLOUR : BG;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lfsr   <= SEED;
            r_px     <= '0;
            r_py     <= '0;
            r_obj_x  <= '0;
            r_obj_y  <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_passed <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_lfsr   <= w_lfsr_nxt;
            r_px     <= w_px_nxt;
            r_py     <= w_py_nxt;
            r_obj_x  <= w_obj_x_nxt;
            r_obj_y  <= w_obj_y_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_colour <= w_colour_nxt;
            r_plot   <= w_plot_nxt;
            r_passed <= w_passed_nxt;
            r_busy   <= w_plot_nxt;
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign obj_x  = r_obj_x;
    assign obj_y  = r_obj_y;
    assign passed = r_passed;
    assign busy   = r_busy;

endmodule

// File: tb/tb_obstacle_animator.sv
// Bench for obstacle_animator: a default 4x4 instance and an 8x2/STEP=3 instance.
// Both are checked against a pass-level model of position, row selection and raster scan.
module tb_obstacle_animator;

    localparam int DIV    = 64;
    localparam int SEED_V = 'h094;

    logic       clk = 1'b0;
    logic       resetn_a = 1'b1, go_a = 1'b0, resetn_b = 1'b1, go_b = 1'b0;
    logic [7:0] x_a, obj_x_a, x_b, obj_x_b;
    logic [6:0] y_a, obj_y_a, y_b, obj_y_b;
    logic [2:0] colour_a, colour_b;
    logic       plot_a, passed_a, busy_a, plot_b, passed_b, busy_b;

    always #5 clk = ~clk;

    obstacle_animator #(.FRAME_DIV(DIV)) u_a (
        .clk(clk), .resetn(resetn_a), .go(go_a), .x(x_a), .y(y_a), .colour(colour_a),
        .plot(plot_a), .obj_x(obj_x_a), .obj_y(obj_y_a), .passed(passed_a), .busy(busy_a)
    );

    obstacle_animator #(.OBJ_W(8), .OBJ_H(2), .STEP(3), .FRAME_DIV(DIV)) u_b (
        .clk(clk), .resetn(resetn_b), .go(go_b), .x(x_b), .y(y_b), .colour(colour_b),
        .plot(plot_b), .obj_x(obj_x_b), .obj_y(obj_y_b), .passed(passed_b), .busy(busy_b)
    );

    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   pulse_a = 0;
    int   pulse_b = 0;
    bit   sel = 1'b0;
    int   qx[$];
    int   qy[$];
    int   qc[$];
    int   busy_err, start_cyc, end_cyc, rel_a;
    logic end_passed;
    int   ox_a, oy_a, lfsr_a, ox_b, oy_b, lfsr_b;

    logic       m_plot, m_busy, m_passed;
    logic [7:0] m_x;
    logic [6:0] m_y;
    logic [2:0] m_c;

    assign m_plot   = sel ? plot_b   : plot_a;
    assign m_busy   = sel ? busy_b   : busy_a;
    assign m_passed = sel ? passed_b : passed_a;
    assign m_x      = sel ? x_b      : x_a;
    assign m_y      = sel ? y_b      : y_a;
    assign m_c      = sel ? colour_b : colour_a;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (passed_a === 1'b1) pulse_a <= pulse_a + 1;
        if (passed_b === 1'b1) pulse_b <= pulse_b + 1;
    end

    // Reference model: 10-bit shift register and row folding, in plain arithmetic.
    function automatic int lfsr_next(int v);
        return ((v << 1) & 'h3FF) | (((v >> 9) ^ (v >> 6)) & 1);
    endfunction

    function automatic int row_of(int v, int ylim);
        int r;
        r = v & 127;
        return (r <= ylim) ? r : r - (ylim + 1);
    endfunction

    // Number of captured pixels that differ from the expected raster of one pass.
    function automatic int pix_err(int ox, int oy, int w, int h, int col);
        int e;
        int i;
        e = 0;
        if (qx.size() != w * h) return w * h + 1;
        for (int py = 0; py < h; py++) begin
            for (int px = 0; px < w; px++) begin
                i = py * w + px;
                if (qx[i] != ox + px || qy[i] != oy + py || qc[i] != col) e++;
            end
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for the next plot burst on the selected instance and records it.
    task automatic cap(input int budget, input int drop_at, output int npix, output bit to);
        int waited;
        waited = 0;
        qx.delete(); qy.delete(); qc.delete();
        busy_err = 0;
        npix = 0;
        to = 1'b0;
        while (m_plot !== 1'b1 && waited < budget) begin
            step();
            waited++;
        end
        if (m_plot !== 1'b1) begin
            to = 1'b1;
            return;
        end
        start_cyc = cyc;
        while (m_plot === 1'b1 && npix < 64) begin
            qx.push_back(int'(m_x));
            qy.push_back(int'(m_y));
            qc.push_back(int'(m_c));
            if (m_busy !== 1'b1) busy_err++;
            if (npix == drop_at) begin
                if (sel) go_b = 1'b0;
                else     go_a = 1'b0;
            end
            npix++;
            step();
        end
        if (m_busy !== 1'b0) busy_err++;
        end_passed = m_passed;
        end_cyc = cyc;
    endtask

    task automatic test_reset();
        #2;
        resetn_a = 1'b0;
        resetn_b = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({x_a, y_a, colour_a, plot_a} !== 19'd0)
            $display("FAIL reset_pixel_port: got %h expected 0", {x_a, y_a, colour_a, plot_a});
        else n_pass++;
        n_checks++;
        if ({obj_x_a, obj_y_a, passed_a, busy_a} !== 17'd0)
            $display("FAIL reset_status: got %h expected 0", {obj_x_a, obj_y_a, passed_a, busy_a});
        else n_pass++;
        n_checks++;
        if ({x_b, y_b, colour_b, plot_b, obj_x_b, obj_y_b, passed_b, busy_b} !== 36'd0)
            $display("FAIL reset_b: got %h expected 0", {x_b, y_b, obj_x_b, obj_y_b});
        else n_pass++;
    endtask

    task automatic test_spawn_draw();
        int n;
        bit to;
        sel = 1'b0;
        ox_a = 156;
        oy_a = row_of(SEED_V, 116);
        lfsr_a = lfsr_next(SEED_V);
        go_a = 1'b1;
        resetn_a = 1'b1;
        rel_a = cyc;
        cap(10, -1, n, to);
        n_checks++;
        if (n != 16 || pix_err(ox_a, oy_a, 4, 4, 7) != 0)
            $display("FAIL spawn_draw: got %0d pixels %0d wrong, expected 16 pixels 0 wrong", n, pix_err(ox_a, oy_a, 4, 4, 7));
        else n_pass++;
        n_checks++;
        if (obj_x_a !== 8'(ox_a) || obj_y_a !== 7'(oy_a))
            $display("FAIL spawn_pos: got (%0d,%0d) expected (%0d,%0d)", obj_x_a, obj_y_a, ox_a, oy_a);
        else n_pass++;
        n_checks++;
        if (start_cyc - rel_a != 2)
            $display("FAIL spawn_latency: got %0d expected 2", start_cyc - rel_a);
        else n_pass++;
        n_checks++;
        if (busy_err != 0)
            $display("FAIL spawn_busy: got %0d busy errors expected 0", busy_err);
        else n_pass++;
    endtask

    task automatic test_tick_move();
        int n;
        int e_end;
        bit to;
        cap(DIV + 40, -1, n, to);
        n_checks++;
        if (n != 16 || pix_err(ox_a, oy_a, 4, 4, 0) != 0)
            $display("FAIL first_erase: got %0d pixels %0d wrong, expected 16 pixels 0 wrong", n, pix_err(ox_a, oy_a, 4, 4, 0));
        else n_pass++;
        n_checks++;
        if (start_cyc - rel_a != DIV)
            $display("FAIL erase_after_tick: got %0d expected %0d", start_cyc - rel_a, DIV);
        else n_pass++;
        e_end = end_cyc;
        ox_a = ox_a - 1;
        cap(10, -1, n, to);
        n_checks++;
        if (n != 16 || pix_err(ox_a, oy_a, 4, 4, 7) != 0 || obj_x_a !== 8'(ox_a))
            $display("FAIL first_move: got obj_x %0d, %0d pixels wrong, expected obj_x %0d 0 wrong", obj_x_a, pix_err(ox_a, oy_a, 4, 4, 7), ox_a);
        else n_pass++;
        n_checks++;
        if (start_cyc - e_end != 1)
            $display("FAIL move_gap: got %0d expected 1", start_cyc - e_end);
        else n_pass++;
    endtask

    task automatic test_run_to_exit();
        int n;
        int errs;
        int p0;
        int e_end;
        bit to;
        errs = 0;
        while (ox_a >= 1) begin
            cap(DIV + 10, -1, n, to);
            errs += pix_err(ox_a, oy_a, 4, 4, 0) + busy_err + int'(end_passed !== 1'b0);
            ox_a = ox_a - 1;
            cap(10, -1, n, to);
            errs += pix_err(ox_a, oy_a, 4, 4, 7) + busy_err;
        end
        n_checks++;
        if (errs != 0 || obj_x_a !== 8'(ox_a))
            $display("FAIL run_passes: got %0d errors obj_x %0d expected 0 errors obj_x %0d", errs, obj_x_a, ox_a);
        else n_pass++;
        p0 = pulse_a;
        cap(DIV + 10, -1, n, to);
        n_checks++;
        if (pix_err(ox_a, oy_a, 4, 4, 0) != 0 || end_passed !== 1'b1)
            $display("FAIL exit_erase: got %0d wrong, passed=%b expected 0 wrong passed=1", pix_err(ox_a, oy_a, 4, 4, 0), end_passed);
        else n_pass++;
        e_end = end_cyc;
        ox_a = 156;
        oy_a = row_of(lfsr_a, 116);
        lfsr_a = lfsr_next(lfsr_a);
        cap(10, -1, n, to);
        n_checks++;
        if (pulse_a - p0 != 1)
            $display("FAIL passed_pulse: got %0d cycles expected 1", pulse_a - p0);
        else n_pass++;
        n_checks++;
        if (obj_x_a !== 8'(ox_a) || obj_y_a !== 7'(oy_a) || pix_err(ox_a, oy_a, 4, 4, 7) != 0)
            $display("FAIL respawn: got (%0d,%0d) expected (%0d,%0d)", obj_x_a, obj_y_a, ox_a, oy_a);
        else n_pass++;
        n_checks++;
        if (start_cyc - e_end != 2)
            $display("FAIL respawn_gap: got %0d expected 2", start_cyc - e_end);
        else n_pass++;
    endtask

    task automatic test_go_drop();
        int n;
        int k;
        int pauses;
        int pc;
        int errs;
        bit to;
        for (int round = 0; round < 2; round++) begin
            k = (round == 0) ? 5 : int'($urandom_range(1, 14));
            pauses = (round == 0) ? 3 : int'($urandom_range(1, 4));
            cap(DIV + 10, -1, n, to);
            errs = pix_err(ox_a, oy_a, 4, 4, 0);
            ox_a = ox_a - 1;
            cap(10, k, n, to);
            n_checks++;
            if (n != 16 || pix_err(ox_a, oy_a, 4, 4, 7) != 0)
                $display("FAIL go_drop_pass: got %0d pixels (drop at %0d) expected 16", n, k);
            else n_pass++;
            pc = 0;
            for (int c = 0; c < pauses * DIV + 8; c++) begin
                step();
                if (plot_a !== 1'b0) pc++;
            end
            n_checks++;
            if (pc != 0 || obj_x_a !== 8'(ox_a))
                $display("FAIL go_hold: got %0d plot cycles obj_x %0d expected 0 and %0d", pc, obj_x_a, ox_a);
            else n_pass++;
            go_a = 1'b1;
            cap(DIV + 4, -1, n, to);
            n_checks++;
            if (pix_err(ox_a, oy_a, 4, 4, 0) != 0 || errs != 0 || to || (start_cyc - rel_a) % DIV != 0)
                $display("FAIL go_resume: got %0d wrong, phase %0d expected 0 wrong phase 0", pix_err(ox_a, oy_a, 4, 4, 0) + errs, (start_cyc - rel_a) % DIV);
            else n_pass++;
            ox_a = ox_a - 1;
            cap(10, -1, n, to);
        end
    endtask

    task automatic test_reset_mid_erase();
        int w;
        int j;
        int n;
        int pc;
        int g;
        bit to;
        w = 0;
        while (plot_a !== 1'b1 && w < DIV + 10) begin
            step();
            w++;
        end
        n_checks++;
        if (plot_a !== 1'b1 || colour_a !== 3'd0)
            $display("FAIL mid_erase_start: got plot=%b colour=%0d expected 1 and 0", plot_a, colour_a);
        else n_pass++;
        j = int'($urandom_range(1, 14));
        repeat (j) step();
        #3;
        resetn_a = 1'b0;
        #1;
        n_checks++;
        if ({x_a, y_a, colour_a, plot_a, busy_a, passed_a, obj_x_a, obj_y_a} !== 36'd0)
            $display("FAIL async_reset: got %h expected 0", {x_a, y_a, colour_a, plot_a, busy_a, passed_a, obj_x_a, obj_y_a});
        else n_pass++;
        step();
        step();
        go_a = 1'b0;
        resetn_a = 1'b1;
        rel_a = cyc;
        pc = 0;
        repeat (2 * DIV + 20) begin
            step();
            if (plot_a !== 1'b0) pc++;
        end
        n_checks++;
        if (pc != 0 || obj_x_a !== 8'd0)
            $display("FAIL idle_hold: got %0d plot cycles obj_x %0d expected 0 and 0", pc, obj_x_a);
        else n_pass++;
        go_a = 1'b1;
        g = cyc;
        oy_a = row_of(SEED_V, 116);
        cap(10, -1, n, to);
        n_checks++;
        if (n != 16 || start_cyc - g != 2 || obj_y_a !== 7'(oy_a) || pix_err(156, oy_a, 4, 4, 7) != 0)
            $display("FAIL reset_respawn: got obj_y %0d latency %0d expected %0d and 2", obj_y_a, start_cyc - g, oy_a);
        else n_pass++;
    endtask

    task automatic test_config_b();
        int n;
        int errs;
        int pc;
        int p0;
        int e_end;
        bit to;
        sel = 1'b1;
        ox_b = 152;
        oy_b = row_of(SEED_V, 118);
        lfsr_b = lfsr_next(SEED_V);
        go_b = 1'b1;
        resetn_b = 1'b1;
        cap(10, -1, n, to);
        n_checks++;
        if (n != 16 || pix_err(ox_b, oy_b, 8, 2, 7) != 0 || obj_x_b !== 8'(ox_b) || obj_y_b !== 7'(oy_b))
            $display("FAIL b_spawn: got %0d pixels at (%0d,%0d) expected 16 at (%0d,%0d)", n, obj_x_b, obj_y_b, ox_b, oy_b);
        else n_pass++;
        errs = 0;
        p0 = pulse_b;
        while (1) begin
            if ($urandom_range(0, 3) == 0) begin
                go_b = 1'b0;
                pc = 0;
                repeat ($urandom_range(70, 200)) begin
                    step();
                    if (plot_b !== 1'b0) pc++;
                end
                errs += pc;
                go_b = 1'b1;
            end
            cap(DIV + 10, -1, n, to);
            errs += pix_err(ox_b, oy_b, 8, 2, 0) + busy_err;
            if (ox_b < 3) break;
            errs += int'(end_passed !== 1'b0);
            ox_b = ox_b - 3;
            cap(10, -1, n, to);
            errs += pix_err(ox_b, oy_b, 8, 2, 7) + busy_err;
        end
        n_checks++;
        if (errs != 0)
            $display("FAIL b_run: got %0d errors expected 0", errs);
        else n_pass++;
        n_checks++;
        if (end_passed !== 1'b1 || obj_x_b !== 8'(ox_b))
            $display("FAIL b_exit: got passed=%b obj_x %0d expected 1 and %0d", end_passed, obj_x_b, ox_b);
        else n_pass++;
        e_end = end_cyc;
        ox_b = 152;
        oy_b = row_of(lfsr_b, 118);
        cap(10, -1, n, to);
        n_checks++;
        if (pulse_b - p0 != 1 || start_cyc - e_end != 2)
            $display("FAIL b_pulse: got %0d pulses gap %0d expected 1 and 2", pulse_b - p0, start_cyc - e_end);
        else n_pass++;
        n_checks++;
        if (obj_x_b !== 8'(ox_b) || obj_y_b !== 7'(oy_b) || pix_err(ox_b, oy_b, 8, 2, 7) != 0)
            $display("FAIL b_respawn: got (%0d,%0d) expected (%0d,%0d)", obj_x_b, obj_y_b, ox_b, oy_b);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_spawn_draw();
        test_tick_move();
        test_run_to_exit();
        test_go_drop();
        test_reset_mid_erase();
        test_config_b();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached with %0d/%0d checks done", n_pass, n_checks);
        $fatal(1, "time limit");
    end

endmodule
